sr_excitation_driver: RTL and testbench

Drives a downstream SR flip-flop so that its output follows a stream of target bits. Targets are queued in a small FIFO, converted to SR excitation codes (never the illegal `11`), and issued one per two-cycle drive/check slot. The flip-flop's `q` is fed back and compared against the tracked expected state. The block is the stimulus side of the SR flip-flop lab: it sits between a test sequencer and the `sr`/`clk` pins of the flip-flop under test.

---
 rtl/sr_excitation_driver_if.sv | 25 ++
 rtl/sr_excitation_driver.sv | 160 ++++++++++++++++
 tb/tb_sr_excitation_driver.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_excitation_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_excitation_driver_if
// Description : Target-bit stream handshake between the test sequencer
//               (master) and the SR excitation driver (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_excitation_driver_if;
  logic in_bit;
  logic in_valid;
  logic in_ready;

  modport master (
    output in_bit,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/sr_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module      : sr_excitation_driver
// Description : Queues target bits in a small FIFO and drives an SR
//               flip-flop towards each target in a two-cycle DRIVE/CHECK
//               slot, comparing the fed-back q against the tracked state.
//               Build macro SRDRV_REFRESH_EN: when defined, hold
//               transitions are driven explicitly (1->1 = 10, 0->0 = 01)
//               instead of the minimal 00 excitation.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_excitation_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sr_excitation_driver_if.slave in_if,
  output logic [1:0]            sr,
  input  logic                  q_fb,
  output logic                  q_exp,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int c_PTR_W = $clog2(DEPTH);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_DRIVE = 2'd1;
  localparam logic [1:0] c_ST_CHECK = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic             r_mem [DEPTH];
  logic [c_PTR_W:0] r_wr_ptr;
  logic [c_PTR_W:0] r_rd_ptr;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_tgt;
  logic [1:0]       r_sr;
  logic             r_q_exp;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_check;
  logic             w_head;
  logic [1:0]       w_sr_nxt;

  // Excitation code that moves the flip-flop from cur to nxt; never 11.
  function automatic logic [1:0] f_excite(input logic cur, input logic nxt);
`ifdef SRDRV_REFRESH_EN
    return (cur == nxt) ? (nxt ? 2'b10 : 2'b01) : {~cur & nxt, cur & ~nxt};
`else
    return {~cur & nxt, cur & ~nxt};
`endif
  endfunction

  // Full/empty come from the pointer registers only, keeping in_ready
  // independent of in_valid.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_push  = in_if.in_valid & ~w_full;
  assign w_head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

  assign in_if.in_ready = ~w_full;
  assign sr      = r_sr;
  assign q_exp   = r_q_exp;
  assign busy    = (r_state != c_ST_IDLE) | ~w_empty;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_PTR_W-1:0]] <= in_if.in_bit;
    end
  end

  // FIFO pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state: DRIVE and CHECK alternate while targets are queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (!w_empty) w_state_nxt = c_ST_DRIVE;
      c_ST_DRIVE: w_state_nxt = c_ST_CHECK;
      c_ST_CHECK: w_state_nxt = w_empty ? c_ST_IDLE : c_ST_DRIVE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs: pop on entry to DRIVE and precompute the code so it is
  // registered onto sr for the DRIVE cycle itself.
  always_comb begin
    w_pop    = 1'b0;
    w_check  = 1'b0;
    w_sr_nxt = 2'b00;
    case (r_state)
      c_ST_IDLE:  w_pop = ~w_empty;
      c_ST_CHECK: begin
        w_pop   = ~w_empty;
        w_check = 1'b1;
      end
      default:    w_pop = 1'b0;
    endcase
    if (w_pop) w_sr_nxt = f_excite(r_q_exp, w_head);
  end

  // Slot datapath: registered excitation, current target and expected state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= 2'b00;
      r_tgt   <= 1'b0;
      r_q_exp <= 1'b0;
    end else begin
      r_sr <= w_sr_nxt;
      if (w_pop) r_tgt <= w_head;
      if (r_state == c_ST_DRIVE) r_q_exp <= r_tgt;
      a_no_illegal_sr: assert (w_sr_nxt != 2'b11);
    end
  end

  // Mismatch tracking: err_clr wins over a same-cycle mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_check && (q_fb != r_q_exp)) begin
      r_err <= 1'b1;
      if (r_err_cnt != c_CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_excitation_driver
// Description : Self-checking bench for sr_excitation_driver with an ideal
//               SR flip-flop on the feedback path and a queue-based
//               reference model of the slot schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_excitation_driver;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             q_fb;
  logic             err_clr;
  logic [1:0]       sr;
  logic             q_exp;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  sr_excitation_driver_if bus ();

  sr_excitation_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_if   (bus),
    .sr      (sr),
    .q_fb    (q_fb),
    .q_exp   (q_exp),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Feedback: 0 = ideal SR flip-flop, 1 = stuck at 0, 2 = random.
  int   fb_mode = 0;
  logic rnd_fb  = 1'b0;
  logic ff_q    = 1'b0;

  always @(posedge clk) begin
    if (rst)                ff_q <= 1'b0;
    else if (sr == 2'b10)   ff_q <= 1'b1;
    else if (sr == 2'b01)   ff_q <= 1'b0;
  end

  assign q_fb = (fb_mode == 0) ? ff_q : (fb_mode == 1) ? 1'b0 : rnd_fb;

  function automatic logic [1:0] exp_code(input logic cur, input logic nxt);
`ifdef SRDRV_REFRESH_EN
    return nxt ? 2'b10 : 2'b01;
`else
    if (cur == nxt) return 2'b00;
    return nxt ? 2'b10 : 2'b01;
`endif
  endfunction

  // Reference model: a queue of targets and a slot countdown
  // (2 = drive cycle in progress, 1 = check cycle, 0 = free).
  bit         mq[$];
  int         m_slot = 0;
  logic       m_qexp = 1'b0;
  logic       m_tgt  = 1'b0;
  logic [1:0] m_sr   = 2'b00;
  logic       m_err  = 1'b0;
  int         m_cnt  = 0;

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_slot = 0; m_qexp = 1'b0; m_tgt = 1'b0; m_sr = 2'b00;
      m_err = 1'b0; m_cnt = 0;
    end else begin
      do_push = bus.in_valid && (mq.size() < DEPTH);
      if (err_clr) begin
        m_err = 1'b0; m_cnt = 0;
      end else if (m_slot == 1 && q_fb != m_qexp) begin
        m_err = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (m_slot == 2) m_qexp = m_tgt;
      do_pop = (m_slot != 2) && (mq.size() > 0);
      if (do_pop) begin
        m_tgt  = mq.pop_front();
        m_sr   = exp_code(m_qexp, m_tgt);
        m_slot = 2;
      end else begin
        m_sr   = 2'b00;
        m_slot = (m_slot == 2) ? 1 : 0;
      end
      if (do_push) mq.push_back(bus.in_bit);
    end
  end

  // Cycle-by-cycle comparison against the model; DRIVE-slot codes are logged.
  bit         mon_en = 1'b0;
  logic [1:0] drv_log[$];

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_sr",       sr,           m_sr);
      chk("mon_q_exp",    q_exp,        m_qexp);
      chk("mon_busy",     busy,         (m_slot != 0) || (mq.size() > 0));
      chk("mon_in_ready", bus.in_ready, mq.size() < DEPTH);
      chk("mon_err",      err,          m_err);
      chk("mon_err_cnt",  err_cnt,      m_cnt);
      if (m_slot == 2) drv_log.push_back(sr);
    end
  end

  task automatic do_reset();
    rst = 1'b1; bus.in_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  typedef struct {
    logic       tgt;
    logic [1:0] code;
  } vec_t;

  vec_t vec[5];

  initial begin
    int nz;
`ifdef SRDRV_REFRESH_EN
    vec[0] = '{1'b1, 2'b10}; vec[1] = '{1'b1, 2'b10}; vec[2] = '{1'b0, 2'b01};
    vec[3] = '{1'b0, 2'b01}; vec[4] = '{1'b1, 2'b10};
`else
    vec[0] = '{1'b1, 2'b10}; vec[1] = '{1'b1, 2'b00}; vec[2] = '{1'b0, 2'b01};
    vec[3] = '{1'b0, 2'b00}; vec[4] = '{1'b1, 2'b10};
`endif
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_bit = 1'b0; err_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    mon_en = 1'b1;
    chk("rst_sr",       sr,           0);
    chk("rst_q_exp",    q_exp,        0);
    chk("rst_err",      err,          0);
    chk("rst_err_cnt",  err_cnt,      0);
    chk("rst_busy",     busy,         0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Target stream 1,1,0,0,1 back-to-back with an ideal flip-flop.
    drv_log.delete();
    for (int i = 0; i < 5; i++) push(vec[i].tgt);
    wait_idle();
    chk("stream_slots", drv_log.size(), 5);
    for (int i = 0; i < 5 && i < drv_log.size(); i++)
      chk("stream_drive_sr", drv_log[i], vec[i].code);
    chk("stream_q_exp", q_exp, 1);
    chk("stream_err",   err,   0);

    // Stuck-at-0 feedback: two bad checks, then clear.
    do_reset();
    fb_mode = 1;
    push(1'b1); push(1'b1);
    @(negedge clk); @(negedge clk);
    chk("mis_err_first", err,     1);
    chk("mis_cnt_first", err_cnt, 1);
    @(negedge clk); @(negedge clk);
    chk("mis_cnt_second", err_cnt, 2);
    wait_idle();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_err", err,     0);
    chk("clr_cnt", err_cnt, 0);

    // Fill the FIFO while slots are running; a push at full is refused.
    do_reset();
    fb_mode = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_bit = (i % 2 == 0);
      @(negedge clk);
    end
    chk("full_ready_low", bus.in_ready, 0);
    bus.in_bit = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    wait_idle();
    chk("full_last_accepted", q_exp, 1);

    // Reset during a DRIVE slot that sets; queued target must be dropped.
    do_reset();
    push(1'b1); push(1'b1);
    chk("latency_sr", sr, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sr",       sr,           0);
    chk("midrst_q_exp",    q_exp,        0);
    chk("midrst_busy",     busy,         0);
    chk("midrst_in_ready", bus.in_ready, 1);
    nz = 0;
    repeat (10) begin
      @(negedge clk);
      if (sr != 2'b00) nz++;
    end
    chk("midrst_no_stale_drive", nz, 0);

    // Counter saturation with a 2-bit counter.
    do_reset();
    fb_mode = 1;
    for (int i = 0; i < 5; i++) push(1'b1);
    wait_idle();
    chk("sat_cnt", err_cnt, CNT_MAX);
    chk("sat_err", err,     1);

    // Random traffic, random feedback, occasional clears and resets.
    do_reset();
    fb_mode = 2;
    repeat (600) begin
      bus.in_valid = ($urandom % 3) != 0;
      bus.in_bit   = 1'($urandom);
      rnd_fb       = 1'($urandom);
      err_clr      = ($urandom % 16) == 0;
      rst          = ($urandom % 80) == 0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0; err_clr = 1'b0; rst = 1'b0;
    wait_idle();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
